// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED pattern sequencer: pattern modes, scan direction
// and the default LED bank width.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_SCAN = 2'd2,
    MODE_HOLD = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam int LED_W_DEFAULT = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a registered one-cycle tick every TICK_DIV
// enabled cycles; enable=0 freezes the count and suppresses the tick.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (enable) begin
      tick    <= (div_cnt == LAST);
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CNT_W'(1);
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: steps a pattern once per prescaler tick in one of four
// modes; mode commands are applied on a tick boundary. LED_PWM_EN adds a
// registered brightness mask driven by a free-running PWM counter.
module led_pattern_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int LED_W    = LED_W_DEFAULT
`ifdef LED_PWM_EN
  ,
  parameter int PWM_BITS = 4
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  mode_t            cmd_mode,
  output mode_t            mode,
  output logic             tick,
  output logic [LED_W-1:0] LED
`ifdef LED_PWM_EN
  ,
  input  logic [PWM_BITS-1:0] brightness
`endif
);

  logic             transfer;
  logic             apply;
  logic             pending;
  logic             pending_next;
  mode_t            pending_mode;
  mode_t            mode_next;
  dir_t             dir;
  dir_t             dir_next;
  logic [LED_W-1:0] pattern;
  logic [LED_W-1:0] pattern_next;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // A transfer can never coincide with an apply: cmd_ready implies no pending.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    transfer     = cmd_valid && cmd_ready;
    apply        = tick && pending;
    pending_next = pending;
    mode_next    = mode;
    dir_next     = dir;
    pattern_next = pattern;

    if (transfer)   pending_next = 1'b1;
    else if (apply) pending_next = 1'b0;

    if (apply) begin
      mode_next = pending_mode;
      case (pending_mode)
        MODE_UP:   pattern_next = '0;
        MODE_DOWN: pattern_next = '1;
        MODE_SCAN: begin
          pattern_next = LED_W'(1);
          dir_next     = DIR_LEFT;
        end
        MODE_HOLD: pattern_next = pattern;
      endcase
    end else if (tick) begin
      case (mode)
        MODE_UP:   pattern_next = pattern + LED_W'(1);
        MODE_DOWN: pattern_next = pattern - LED_W'(1);
        MODE_SCAN: begin
          // The end bit is shown for one tick; the turn happens on the next step.
          if (dir == DIR_LEFT) begin
            if (pattern[LED_W-1]) begin
              dir_next     = DIR_RIGHT;
              pattern_next = pattern >> 1;
            end else begin
              pattern_next = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              dir_next     = DIR_LEFT;
              pattern_next = pattern << 1;
            end else begin
              pattern_next = pattern >> 1;
            end
          end
        end
        MODE_HOLD: pattern_next = pattern;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern      <= '0;
      mode         <= MODE_UP;
      dir          <= DIR_LEFT;
      pending      <= 1'b0;
      pending_mode <= MODE_UP;
      cmd_ready    <= 1'b0;
    end else begin
      pattern   <= pattern_next;
      mode      <= mode_next;
      dir       <= dir_next;
      pending   <= pending_next;
      cmd_ready <= !pending_next;
      if (transfer) pending_mode <= cmd_mode;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt <= '0;
      LED     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      LED     <= pattern & {LED_W{pwm_cnt < brightness}};
    end
  end
`else
  assign LED = pattern;
`endif

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Controller that sequences the board LED bank: divides the 50 MHz system clock into a pattern tick and steps a 10-bit LED pattern once per tick. Four modes are selectable: count up, count down, bouncing scan and hold. Mode changes arrive over a valid/ready command port and take effect only on a tick boundary. Sits between board-level control logic (switches/buttons or a soft CPU) and the LED pins.

Parameters:
TICK_DIV, 50_000_000, clock cycles per pattern tick (1 Hz at 50 MHz); minimum 2.
LED_W, 10, number of LEDs; minimum 2.
PWM_BITS, 4, brightness resolution; used only with LED_PWM_EN.

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
enable  in  1  1 = prescaler runs; 0 = freeze prescaler and pattern
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted
cmd_mode  in  2  requested mode (mode_t)
mode  out  2  currently applied mode
tick  out  1  one-cycle pulse per pattern step
LED  out  LED_W  LED drive, 1 = on

Behaviour:
- Reset (sync, active-high): LED=0, mode=MODE_UP, tick=0, div_cnt=0, pending=0, cmd_ready=0. cmd_ready rises in the first cycle after reset deasserts. Reset mid-operation discards any pending command.
- Prescaler: div_cnt increments when enable=1 and wraps TICK_DIV-1 -> 0. tick is registered; it is 1 in the cycle after div_cnt==TICK_DIV-1. enable=0 holds div_cnt and forces tick=0.
- Command handshake: a transfer occurs when cmd_valid && cmd_ready. On transfer, pending_mode is latched, pending=1, and cmd_ready=0 from the next cycle. cmd_ready=!pending (registered).
- Mode apply: on the first tick strictly after the transfer cycle:
  - mode <= pending_mode; pending clears and cmd_ready returns to 1 the next cycle.
  - LED loads the entry value, with no step on this tick: UP -> 0; DOWN -> all ones; SCAN -> bit0 set, direction left; HOLD -> unchanged.
  - A transfer in the same cycle as a tick is applied at the following tick. The current tick steps using the old mode.
- Step on tick with no apply:
  - UP: LED+1, wrapping all-ones -> 0.
  - DOWN: LED-1, wrapping 0 -> all ones.
  - SCAN: one-hot shift in the current direction. At bit LED_W-1 the direction flips right and the next step goes to bit LED_W-2. At bit0 the direction flips left. The end bit is shown for exactly one tick.
  - HOLD: no change.
- All arithmetic is modulo 2^LED_W. All four mode_t encodings are legal.
- Outputs change only on the clock edge; there are no combinational paths from inputs to outputs.

Optional Feature:
LED_PWM_EN
- Defined:
  - Adds input port brightness[PWM_BITS-1:0].
  - Adds a free-running pwm_cnt[PWM_BITS-1:0] (reset 0). It runs regardless of enable.
  - LED = pattern & {LED_W{pwm_cnt < brightness}}. brightness=0 gives all LEDs off; maximum brightness gives (2^PWM_BITS-1)/2^PWM_BITS duty.
  - The masking stage is registered and adds 1 cycle of LED latency.
- Undefined: no brightness port; LED = pattern register directly.

Decomposition:
- Package led_ctrl_pkg:
  - typedef enum logic [1:0] mode_t {MODE_UP=0, MODE_DOWN=1, MODE_SCAN=2, MODE_HOLD=3}.
  - typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t.
  - localparam LED_W_DEFAULT=10.
- Sub-module tick_prescaler (TICK_DIV; clock, reset, enable -> tick). Pattern and command logic stay in the top.

Test Plan (TICK_DIV=4, LED_W=10):
1. Hold reset 3 cycles, then release -> LED=000, mode=UP, cmd_ready=1 one cycle later. First tick 4 cycles after release gives LED=001. After 1023 ticks LED=3FF; the next tick gives 000.
2. Send cmd_mode=DOWN mid-period -> cmd_ready=0 until apply. At the next tick LED=3FF and mode=DOWN; following ticks give 3FE, 3FD.
3. Apply SCAN -> entry LED=001. Ticks 1..9 give 002..200; tick 10 gives 100; tick 18 gives 001; tick 19 gives 002.
4. Assert cmd_valid (HOLD) exactly in a tick cycle while in UP with LED=005 -> that tick gives LED=006 and mode still UP. The next tick applies HOLD with LED=006, and LED stays 006 thereafter.
5. Drop enable for 10 cycles mid-period -> tick=0 and LED stable. After re-enable, the next tick arrives after the remaining div_cnt cycles, not a full period.
6. Accept a HOLD command, then assert reset before the tick -> mode=UP, LED=000, pending cleared. After reset, ticks count 001, 002 (the HOLD command is never applied).
